// File: rtl/sobel_window_ctrl.sv
// Frame-scan controller for a 3x3 Sobel line buffer: walks a ROWS x COLS raster,
// drives buffer clear/shift and flags each complete window with its centre pixel.
module sobel_window_ctrl #(
  parameter int unsigned ROWS = 480,
  parameter int unsigned COLS = 640
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  output logic        buf_clr_o,
  output logic        buf_en_o,
  output logic        win_valid_o,
  output logic [15:0] center_row_o,
  output logic [15:0] center_col_o,
  output logic        busy_o,
  output logic        frame_done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] ROW_LAST = 16'(ROWS - 1);
  localparam logic [15:0] COL_LAST = 16'(COLS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] row;
  logic [15:0] col;
  logic        accept;
  logic        last_col;
  logic        last_pix;
  logic        win_hit;

  // Status outputs decode straight from the state register, so an asynchronous
  // reset drops them all to zero without waiting for a clock edge.
  assign pix_ready_o  = (state == RUN);
  assign buf_clr_o    = (state == CLEAR);
  assign busy_o       = (state != IDLE);
  assign frame_done_o = (state == DONE);
  assign accept       = pix_valid_i & pix_ready_o;
  assign buf_en_o     = accept;

  assign last_col = (col == COL_LAST);
  assign last_pix = last_col && (row == ROW_LAST);
  assign win_hit  = accept && !abort_i && (row >= 16'd2) && (col >= 16'd2);

  // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (abort_i) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start_i) state_nxt = CLEAR;
        CLEAR:   state_nxt = RUN;
        RUN:     if (accept && last_pix) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (abort_i || state == CLEAR) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= (row == ROW_LAST) ? 16'd0 : row + 16'd1;
      end else begin
        col <= col + 16'd1;
      end
    end
  end

  // The window at the buffer output is centred one row and one column behind
  // the pixel just shifted in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid_o  <= 1'b0;
      center_row_o <= '0;
      center_col_o <= '0;
    end else begin
      win_valid_o <= win_hit;
      if (win_hit) begin
        center_row_o <= row - 16'd1;
        center_col_o <= col - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl: a 5x6 instance for the main scenarios
// and a 3x3 instance for the minimum-frame boundary, sharing one input set.
module tb_sobel_window_ctrl;

  localparam int S_IDLE  = 0;
  localparam int S_CLEAR = 1;
  localparam int S_RUN   = 2;
  localparam int S_DONE  = 3;

  typedef struct {
    int r;
    int c;
  } centre_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_i = 1'b0;
  logic abort_i = 1'b0;
  logic pix_valid_i = 1'b0;

  logic        a_ready, a_clr, a_en, a_win, a_busy, a_done;
  logic [15:0] a_crow, a_ccol;
  logic        b_ready, b_clr, b_en, b_win, b_busy, b_done;
  logic [15:0] b_crow, b_ccol;

  sobel_window_ctrl #(.ROWS(5), .COLS(6)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .pix_valid_i(pix_valid_i), .pix_ready_o(a_ready), .buf_clr_o(a_clr),
    .buf_en_o(a_en), .win_valid_o(a_win), .center_row_o(a_crow),
    .center_col_o(a_ccol), .busy_o(a_busy), .frame_done_o(a_done)
  );

  sobel_window_ctrl #(.ROWS(3), .COLS(3)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .pix_valid_i(pix_valid_i), .pix_ready_o(b_ready), .buf_clr_o(b_clr),
    .buf_en_o(b_en), .win_valid_o(b_win), .center_row_o(b_crow),
    .center_col_o(b_ccol), .busy_o(b_busy), .frame_done_o(b_done)
  );

  always #5 clk = ~clk;

  // Observed outputs of whichever instance is under test.
  bit          sel = 1'b0;
  logic        o_ready, o_clr, o_en, o_win, o_busy, o_done;
  logic [15:0] o_crow, o_ccol;
  assign o_ready = sel ? b_ready : a_ready;
  assign o_clr   = sel ? b_clr   : a_clr;
  assign o_en    = sel ? b_en    : a_en;
  assign o_win   = sel ? b_win   : a_win;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_crow  = sel ? b_crow  : a_crow;
  assign o_ccol  = sel ? b_ccol  : a_ccol;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the controller, built from the frame-scan rules.
  centre_t exp_q[$];
  int m_rows = 5;
  int m_cols = 6;
  int m_state = S_IDLE;
  int m_row = 0;
  int m_col = 0;
  int m_crow = 0;
  int m_ccol = 0;

  // Per-frame observations.
  int cyc = 0;
  int start_cyc, done_cyc;
  int n_acc, n_win, n_clr, n_done;
  int first_win_acc, first_r, first_c, last_r, last_c;

  task automatic model_reset();
    m_state = S_IDLE;
    m_row   = 0;
    m_col   = 0;
    m_crow  = 0;
    m_ccol  = 0;
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs, then
  // advance the model to what the next rising edge should produce.
  task automatic cycle(input bit v, input bit s, input bit ab, input bit do_rst);
    bit      acc;
    bit      ew;
    centre_t e;
    logic [4:0] exp_st;
    @(negedge clk);
    pix_valid_i = v;
    start_i     = s;
    abort_i     = ab;
    #1;
    cyc++;
    acc = v && (m_state == S_RUN);
    ew  = (exp_q.size() != 0);
    if (ew) begin
      e      = exp_q.pop_front();
      m_crow = e.r;
      m_ccol = e.c;
    end
    n_cmp++;
    if (o_win !== ew) begin
      n_bad++;
      $display("FAIL win_valid cyc=%0d got=%b want=%b", cyc, o_win, ew);
    end
    n_cmp++;
    if ({o_crow, o_ccol} !== {16'(m_crow), 16'(m_ccol)}) begin
      n_bad++;
      $display("FAIL centre cyc=%0d got=(%0d,%0d) want=(%0d,%0d)",
               cyc, o_crow, o_ccol, m_crow, m_ccol);
    end
    exp_st = {m_state == S_RUN, m_state != S_IDLE, m_state == S_CLEAR, acc, m_state == S_DONE};
    n_cmp++;
    if ({o_ready, o_busy, o_clr, o_en, o_done} !== exp_st) begin
      n_bad++;
      $display("FAIL status{ready,busy,clr,en,done} cyc=%0d got=%b want=%b",
               cyc, {o_ready, o_busy, o_clr, o_en, o_done}, exp_st);
    end
    if (o_win === 1'b1) begin
      n_win++;
      if (n_win == 1) begin
        first_win_acc = n_acc;
        first_r = int'(o_crow);
        first_c = int'(o_ccol);
      end
      last_r = int'(o_crow);
      last_c = int'(o_ccol);
    end
    if (o_clr === 1'b1) n_clr++;
    if (o_done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (acc) n_acc++;

    if (ab) begin
      m_state = S_IDLE;
      m_row   = 0;
      m_col   = 0;
    end else begin
      case (m_state)
        S_IDLE:  if (s) m_state = S_CLEAR;
        S_CLEAR: begin
          m_row   = 0;
          m_col   = 0;
          m_state = S_RUN;
        end
        S_RUN: if (acc) begin
          if (m_row >= 2 && m_col >= 2) exp_q.push_back('{r: m_row - 1, c: m_col - 1});
          if (m_row == m_rows - 1 && m_col == m_cols - 1) m_state = S_DONE;
          if (m_col == m_cols - 1) begin
            m_col = 0;
            m_row = (m_row == m_rows - 1) ? 0 : m_row + 1;
          end else begin
            m_col++;
          end
        end
        default: m_state = S_IDLE;
      endcase
    end

    if (do_rst) begin
      #1 rst = 1'b0;
      #1;
      n_cmp++;
      if ({o_ready, o_busy, o_clr, o_en, o_done, o_win, o_crow, o_ccol} !== 38'd0) begin
        n_bad++;
        $display("FAIL async_reset outputs got=%b want=all zero",
                 {o_ready, o_busy, o_clr, o_en, o_done, o_win, o_crow, o_ccol});
      end
      model_reset();
      #1 rst = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Start a frame and feed pixels until the model returns to IDLE. Events are
  // keyed to the accept index (1-based); -1 disables an event.
  task automatic run_frame(input int stall_a, input int stall_b, input int restart_at,
                           input int abort_at, input int rst_at);
    int stall = 0;
    int guard = 0;
    bit v, s, ab, r, will;
    n_acc = 0; n_win = 0; n_clr = 0; n_done = 0;
    first_win_acc = -1; first_r = -1; first_c = -1; last_r = -1; last_c = -1;
    done_cyc = -1;
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    start_cyc = cyc;
    while (m_state != S_IDLE && guard < 400) begin
      guard++;
      v = (stall == 0);
      if (stall > 0) stall--;
      will = v && (m_state == S_RUN);
      s    = will && (n_acc + 1 == restart_at);
      ab   = will && (n_acc + 1 == abort_at);
      r    = will && (n_acc + 1 == rst_at);
      cycle(v, s, ab, r);
      if (will && (n_acc == stall_a || n_acc == stall_b)) stall = 3;
    end
    if (guard >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout got=%0d cycles want<400", guard);
    end
    pix_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({a_ready, a_busy, a_clr, a_en, a_done, a_win, a_crow, a_ccol} !== 38'd0) begin
      n_bad++;
      $display("FAIL reset_a got=%b want=all zero",
               {a_ready, a_busy, a_clr, a_en, a_done, a_win, a_crow, a_ccol});
    end
    n_cmp++;
    if ({b_ready, b_busy, b_clr, b_en, b_done, b_win, b_crow, b_ccol} !== 38'd0) begin
      n_bad++;
      $display("FAIL reset_b got=%b want=all zero",
               {b_ready, b_busy, b_clr, b_en, b_done, b_win, b_crow, b_ccol});
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    idle_cycles(2);
  endtask

  task automatic test_full_frame();
    run_frame(-1, -1, -1, -1, -1);
    idle_cycles(2);
    n_cmp++;
    if ({n_clr, n_acc, n_win, n_done} !== {32'd1, 32'd30, 32'd12, 32'd1}) begin
      n_bad++;
      $display("FAIL full_counts clr/acc/win/done got=%0d/%0d/%0d/%0d want=1/30/12/1",
               n_clr, n_acc, n_win, n_done);
    end
    n_cmp++;
    if (first_r !== 1 || first_c !== 1 || first_win_acc !== 15) begin
      n_bad++;
      $display("FAIL full_first got=(%0d,%0d)@acc%0d want=(1,1)@acc15", first_r, first_c, first_win_acc);
    end
    n_cmp++;
    if (last_r !== 3 || last_c !== 4) begin
      n_bad++;
      $display("FAIL full_last got=(%0d,%0d) want=(3,4)", last_r, last_c);
    end
    n_cmp++;
    if (done_cyc - start_cyc !== 32) begin
      n_bad++;
      $display("FAIL full_done_latency got=%0d want=32", done_cyc - start_cyc);
    end
  endtask

  task automatic test_stall();
    run_frame(10, 20, -1, -1, -1);
    idle_cycles(2);
    n_cmp++;
    if ({n_acc, n_win, n_done} !== {32'd30, 32'd12, 32'd1}) begin
      n_bad++;
      $display("FAIL stall_counts acc/win/done got=%0d/%0d/%0d want=30/12/1", n_acc, n_win, n_done);
    end
    n_cmp++;
    if (done_cyc - start_cyc !== 38) begin
      n_bad++;
      $display("FAIL stall_done_latency got=%0d want=38", done_cyc - start_cyc);
    end
  endtask

  task automatic test_start_ignored();
    run_frame(-1, -1, 8, -1, -1);
    idle_cycles(2);
    n_cmp++;
    if ({n_clr, n_acc, n_win, n_done} !== {32'd1, 32'd30, 32'd12, 32'd1}) begin
      n_bad++;
      $display("FAIL restart_counts clr/acc/win/done got=%0d/%0d/%0d/%0d want=1/30/12/1",
               n_clr, n_acc, n_win, n_done);
    end
  endtask

  task automatic test_abort();
    run_frame(-1, -1, -1, 17, -1);
    idle_cycles(3);
    n_cmp++;
    if ({n_acc, n_win, n_done} !== {32'd17, 32'd2, 32'd0}) begin
      n_bad++;
      $display("FAIL abort_counts acc/win/done got=%0d/%0d/%0d want=17/2/0", n_acc, n_win, n_done);
    end
    run_frame(-1, -1, -1, -1, -1);
    idle_cycles(2);
    n_cmp++;
    if ({n_acc, n_win, n_done, first_win_acc} !== {32'd30, 32'd12, 32'd1, 32'd15}) begin
      n_bad++;
      $display("FAIL abort_refill acc/win/done/firstacc got=%0d/%0d/%0d/%0d want=30/12/1/15",
               n_acc, n_win, n_done, first_win_acc);
    end
  endtask

  task automatic test_reset_mid_frame();
    run_frame(-1, -1, -1, -1, 20);
    idle_cycles(2);
    n_cmp++;
    if ({n_acc, n_done} !== {32'd20, 32'd0}) begin
      n_bad++;
      $display("FAIL rst_mid_counts acc/done got=%0d/%0d want=20/0", n_acc, n_done);
    end
    run_frame(-1, -1, -1, -1, -1);
    idle_cycles(2);
    n_cmp++;
    if ({n_acc, n_win, n_done, first_r, first_c} !== {32'd30, 32'd12, 32'd1, 32'd1, 32'd1}) begin
      n_bad++;
      $display("FAIL rst_refill acc/win/done/first got=%0d/%0d/%0d/(%0d,%0d) want=30/12/1/(1,1)",
               n_acc, n_win, n_done, first_r, first_c);
    end
  endtask

  task automatic test_boundary_3x3();
    @(negedge clk);
    rst = 1'b0;
    #2 rst = 1'b1;
    sel = 1'b1;
    m_rows = 3;
    m_cols = 3;
    model_reset();
    run_frame(-1, -1, -1, -1, -1);
    idle_cycles(2);
    n_cmp++;
    if ({n_acc, n_win, n_done} !== {32'd9, 32'd1, 32'd1}) begin
      n_bad++;
      $display("FAIL b3x3_counts acc/win/done got=%0d/%0d/%0d want=9/1/1", n_acc, n_win, n_done);
    end
    n_cmp++;
    if (first_r !== 1 || first_c !== 1 || first_win_acc !== 9) begin
      n_bad++;
      $display("FAIL b3x3_centre got=(%0d,%0d)@acc%0d want=(1,1)@acc9", first_r, first_c, first_win_acc);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL b3x3_pending got=%0d want=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_start_ignored();
    test_abort();
    test_reset_mid_frame();
    test_boundary_3x3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
